shift_reg_univ: RTL
===================

// Module: shift_reg_univ
// PURPOSE
//   Parametrised universal shift register: the multi-bit, multi-mode successor of the
//   single-bit enabled D flip-flop. Supports hold, parallel load, logical shifts,
//   rotates and arithmetic shift right, each gated by an optional enable.
//   A shift counter and a done pulse let it act as a serialiser/deserialiser for
//   serial-link and datapath blocks.
// PARAMETERS
//   WIDTH      8   register width in bits; legal range >= 2
//   USE_EN     1   1: en gates all updates except clr; 0: en ignored, treated as 1
//   RESET_VAL  0   WIDTH-bit value loaded into q on reset and on clr
// PORTS
//   clk        in   1                   clock, rising-edge active
//   rst        in   1                   asynchronous, active-low reset
//   en         in   1                   update enable (see USE_EN)
//   clr        in   1                   synchronous clear, independent of en
//   mode       in   3                   operation select, decoded below
//   d          in   WIDTH               parallel load data
//   sin        in   1                   serial input bit
//   q          out  WIDTH               register contents
//   sout       out  1                   registered bit shifted/rotated out by last op
//   shift_cnt  out  $clog2(WIDTH+1)     shift/rotate ops since last load/clr, saturating
//   done       out  1                   one-cycle pulse when shift_cnt reaches WIDTH
// BEHAVIOUR
//   - rst low: immediately, without waiting for a clock edge, q=RESET_VAL,
//     sout=0, shift_cnt=0 and done=0. Held while rst is low.
//   - All other state updates occur on the rising edge of clk. Latency is 1 cycle.
//   - Priority: rst > clr > enable gate > mode.
//   - clr=1: q=RESET_VAL, sout=0, shift_cnt=0, done=0. en and mode are ignored.
//   - en=0 (USE_EN=1): q, sout and shift_cnt hold; done=0.
//   - mode decode when enabled:
//       000 hold
//       001 load: q=d, shift_cnt=0, sout unchanged
//       010 shl:  q={q[W-2:0],sin},     sout=q[W-1]
//       011 shr:  q={sin,q[W-1:1]},     sout=q[0]
//       100 rotl: q={q[W-2:0],q[W-1]},  sout=q[W-1]
//       101 rotr: q={q[0],q[W-1:1]},    sout=q[0]
//       110 asr:  q={q[W-1],q[W-1:1]},  sout=q[0]
//       111 reserved; behaves as hold
//   - Each enabled 010..110 op increments shift_cnt, saturating at WIDTH.
//   - done is registered: it is 1 only in the cycle after the edge on which
//     shift_cnt goes from WIDTH-1 to WIDTH. It is 0 in every other cycle,
//     including further ops while saturated.
//   - rst deasserted mid-operation: the operation resumes from reset state.
//     No partial shift is retained.
// TESTING (WIDTH=8, RESET_VAL=0, sample at negedge)
//   1. Set q=8'hA5, then drop rst between edges -> q=00, sout=0, shift_cnt=0 and
//      done=0 before the next posedge.
//   2. Load 8'hA5 with en=1, then en=0 with mode=shl, sin=0 -> q=A5 holds.
//      In a USE_EN=0 build the same stimulus gives q=4A and sout=1.
//   3. Load 8'h81 -> rotl gives 03 (sout=1) -> rotr gives 81 -> rotr gives C0.
//   4. Load 8'h90 then asr -> q=C8, sout=0.
//      Load 8'h01 then shr with sin=1 -> q=80, sout=1.
//   5. Load 8'hFF, then 8 shl ops with sin=0 -> shift_cnt goes 1..8 and q=00.
//      done=1 only after the 8th edge. A 9th shl gives shift_cnt=8 and done=0.
//   6. clr=1 with en=0, mode=load, d=8'h3C in the same cycle -> q=00, shift_cnt=0.
//      The load is ignored.

Source files
------------

// File: rtl/shift_reg_univ_if.sv
// Bus bundle for the universal shift register: control/data inputs and observable state.
interface shift_reg_univ_if #(
  parameter int unsigned WIDTH = 8
) ();
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             en;
  logic             clr;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic [CW-1:0]    shift_cnt;
  logic             done;

  modport master (
    output en, clr, mode, d, sin,
    input  q, sout, shift_cnt, done
  );

  modport slave (
    input  en, clr, mode, d, sin,
    output q, sout, shift_cnt, done
  );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, parallel load, logical shifts, rotates and arithmetic
// shift right, with a saturating shift counter and a one-cycle done pulse.
module shift_reg_univ #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      USE_EN    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic             clk,
  input logic             rst,
  shift_reg_univ_if.slave bus
);
  localparam int unsigned   CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CntMax   = CW'(WIDTH);
  localparam logic [CW-1:0] CntLast  = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    ModeHold = 3'b000,
    ModeLoad = 3'b001,
    ModeShl  = 3'b010,
    ModeShr  = 3'b011,
    ModeRotl = 3'b100,
    ModeRotr = 3'b101,
    ModeAsr  = 3'b110,
    ModeRsvd = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             en_eff;
  logic             is_shift;
  mode_e            mode;

  assign en_eff = (USE_EN == 0) ? 1'b1 : bus.en;
  assign mode   = mode_e'(bus.mode);

  // Next-state: clr beats the enable gate, which beats the mode decode.
  always_comb begin
    q_d      = q_q;
    sout_d   = sout_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    is_shift = 1'b0;
    if (bus.clr) begin
      q_d    = RESET_VAL;
      sout_d = 1'b0;
      cnt_d  = '0;
    end else if (en_eff) begin
      case (mode)
        ModeLoad: begin
          q_d   = bus.d;
          cnt_d = '0;
        end
        ModeShl: begin
          q_d      = {q_q[WIDTH-2:0], bus.sin};
          sout_d   = q_q[WIDTH-1];
          is_shift = 1'b1;
        end
        ModeShr: begin
          q_d      = {bus.sin, q_q[WIDTH-1:1]};
          sout_d   = q_q[0];
          is_shift = 1'b1;
        end
        ModeRotl: begin
          q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_d   = q_q[WIDTH-1];
          is_shift = 1'b1;
        end
        ModeRotr: begin
          q_d      = {q_q[0], q_q[WIDTH-1:1]};
          sout_d   = q_q[0];
          is_shift = 1'b1;
        end
        ModeAsr: begin
          q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          sout_d   = q_q[0];
          is_shift = 1'b1;
        end
        default: ;  // hold and reserved encoding
      endcase
      // Counter saturates; done fires only on the WIDTH-1 -> WIDTH transition.
      if (is_shift && (cnt_q != CntMax)) begin
        cnt_d  = cnt_q + CW'(1);
        done_d = (cnt_q == CntLast);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= RESET_VAL;
      sout_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.sout      = sout_q;
  assign bus.shift_cnt = cnt_q;
  assign bus.done      = done_q;
endmodule
